// File: rtl/cr_xp10_decomp_lz77_pfx_ld_pkg.sv
`default_nettype none
// ============================================================================
// cr_xp10_decompPKG
// Shared types and constants for the XP10 decompressor prefix loader.
// Revision: 1.0
// ============================================================================
package cr_xp10_decompPKG;

    typedef enum logic [1:0] {
        PFX_LD_IDLE = 2'd0,
        PFX_LD_LOAD = 2'd1,
        PFX_LD_DONE = 2'd2
    } pfx_ld_state_e;

    localparam int          PFX_NUM_SLOTS = 3;
    localparam logic [11:0] USR_BASE_ADDR = 12'd64;
    localparam logic [1:0]  PFX_SEL_NONE  = 2'd3;

    // Slot select to in-use mask; the "no prefix" code maps to an empty mask.
    function automatic logic [PFX_NUM_SLOTS-1:0] pfx_onehot(input logic [1:0] sel);
        logic [PFX_NUM_SLOTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < PFX_NUM_SLOTS; i++) begin
            if (sel == 2'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cr_xp10_decomp_lz77_pfx_ld.sv
`default_nettype none
// ============================================================================
// cr_xp10_decomp_lz77_pfx_ld
// Loads 128-bit prefix words into one of three history-buffer prefix slots,
// tracks per-frame slot usage and optionally forwards user data
// (user path enabled by macro CR_XP10_DECOMP_PFX_LD_USR_EN).
// Revision: 1.0
// ============================================================================
module cr_xp10_decomp_lz77_pfx_ld
    import cr_xp10_decompPKG::*;
#(
    parameter int PFX_WORDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         pld_req,
    input  logic [1:0]   pld_sel,
    output logic         pld_ack,
    input  logic         pld_valid,
    input  logic [127:0] pld_data,
    output logic         pld_ready,
    output logic         pld_done,

    input  logic         frm_start,
    input  logic [1:0]   frm_pfx_sel,
    input  logic         ag_hb_eof,

    output logic         pl_hb_pfx0_pld_wr,
    output logic [5:0]   pl_hb_pfx0_pld_waddr,
    output logic [127:0] pl_hb_pfx0_pld_wdata,
    output logic         pl_hb_pfx1_pld_wr,
    output logic [5:0]   pl_hb_pfx1_pld_waddr,
    output logic [127:0] pl_hb_pfx1_pld_wdata,
    output logic         pl_hb_pfx2_pld_wr,
    output logic [5:0]   pl_hb_pfx2_pld_waddr,
    output logic [127:0] pl_hb_pfx2_pld_wdata,

    output logic         pl_hb_pfx0_in_use,
    output logic         pl_hb_pfx1_in_use,
    output logic         pl_hb_pfx2_in_use,

    input  logic         usr_valid,
    input  logic [127:0] usr_data,
    output logic         usr_ready,
    output logic         pl_hb_usr_wr,
    output logic [127:0] pl_hb_usr_wdata,
    output logic [11:0]  pl_hb_usr_waddr,

    output logic         pfx_conflict_err
);

    localparam logic [5:0] LAST_WADDR = 6'(PFX_WORDS - 1);

    pfx_ld_state_e              state_q;
    logic [5:0]                 cnt_q;
    logic [1:0]                 ld_sel_q;
    logic                       ready_q;
    logic                       done_q;
    logic [PFX_NUM_SLOTS-1:0]   in_use_q;
    logic [PFX_NUM_SLOTS-1:0]   wr_q;
    logic [5:0]                 waddr_q [PFX_NUM_SLOTS];
    logic [127:0]               wdata_q [PFX_NUM_SLOTS];
    logic                       conflict_q;

    logic [3:0]                 w_busy;
    logic                       w_accept;
    logic                       w_beat;

    // Slot 3 ("no prefix") is always treated as busy so it is never accepted.
    assign w_busy   = {1'b1, in_use_q};
    assign w_accept = (state_q == PFX_LD_IDLE) && pld_req && !w_busy[pld_sel];
    assign w_beat   = pld_valid && ready_q;

    assign pld_ack   = w_accept;
    assign pld_ready = ready_q;
    assign pld_done  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PFX_LD_IDLE;
            cnt_q    <= '0;
            ld_sel_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                PFX_LD_IDLE: begin
                    if (w_accept) begin
                        state_q  <= PFX_LD_LOAD;
                        ld_sel_q <= pld_sel;
                        cnt_q    <= '0;
                        ready_q  <= 1'b1;
                    end
                end
                PFX_LD_LOAD: begin
                    if (w_beat) begin
                        if (cnt_q == LAST_WADDR) begin
                            state_q <= PFX_LD_DONE;
                            cnt_q   <= '0;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                PFX_LD_DONE: begin
                    state_q <= PFX_LD_IDLE;
                end
                default: begin
                    state_q <= PFX_LD_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            in_use_q   <= '0;
            conflict_q <= 1'b0;
            for (int i = 0; i < PFX_NUM_SLOTS; i++) begin
                waddr_q[i] <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PFX_NUM_SLOTS; i++) begin
                wr_q[i] <= w_beat && (ld_sel_q == 2'(i));
                if (w_beat && (ld_sel_q == 2'(i))) begin
                    waddr_q[i] <= cnt_q;
                    wdata_q[i] <= pld_data;
                end
            end
            // A new frame's selection takes precedence over the old frame's end.
            if (frm_start) begin
                in_use_q <= pfx_onehot(frm_pfx_sel);
            end else if (ag_hb_eof) begin
                in_use_q <= '0;
            end
            conflict_q <= frm_start && (state_q == PFX_LD_LOAD) && (frm_pfx_sel == ld_sel_q);
        end
    end

    assign pfx_conflict_err = conflict_q;

    assign pl_hb_pfx0_pld_wr    = wr_q[0];
    assign pl_hb_pfx0_pld_waddr = waddr_q[0];
    assign pl_hb_pfx0_pld_wdata = wdata_q[0];
    assign pl_hb_pfx1_pld_wr    = wr_q[1];
    assign pl_hb_pfx1_pld_waddr = waddr_q[1];
    assign pl_hb_pfx1_pld_wdata = wdata_q[1];
    assign pl_hb_pfx2_pld_wr    = wr_q[2];
    assign pl_hb_pfx2_pld_waddr = waddr_q[2];
    assign pl_hb_pfx2_pld_wdata = wdata_q[2];

    assign pl_hb_pfx0_in_use = in_use_q[0];
    assign pl_hb_pfx1_in_use = in_use_q[1];
    assign pl_hb_pfx2_in_use = in_use_q[2];

`ifdef CR_XP10_DECOMP_PFX_LD_USR_EN
    logic         usr_en_q;
    logic         usr_wr_q;
    logic [127:0] usr_wdata_q;
    logic [11:0]  usr_waddr_q;
    logic [11:0]  usr_addr_q;

    assign usr_ready = usr_en_q && !ag_hb_eof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usr_en_q    <= 1'b0;
            usr_wr_q    <= 1'b0;
            usr_wdata_q <= '0;
            usr_waddr_q <= USR_BASE_ADDR;
            usr_addr_q  <= USR_BASE_ADDR;
        end else begin
            usr_en_q <= 1'b1;
            usr_wr_q <= usr_valid && usr_ready;
            if (usr_valid && usr_ready) begin
                usr_wdata_q <= usr_data;
                usr_waddr_q <= usr_addr_q;
                // Saturate at the top of the history buffer rather than wrapping.
                if (usr_addr_q != 12'hFFF) usr_addr_q <= usr_addr_q + 12'd1;
            end
            if (ag_hb_eof) usr_addr_q <= USR_BASE_ADDR;
        end
    end

    assign pl_hb_usr_wr    = usr_wr_q;
    assign pl_hb_usr_wdata = usr_wdata_q;
    assign pl_hb_usr_waddr = usr_waddr_q;
`else
    logic unused_usr_in;
    assign unused_usr_in   = ^{usr_valid, usr_data};
    assign usr_ready       = 1'b0;
    assign pl_hb_usr_wr    = 1'b0;
    assign pl_hb_usr_wdata = '0;
    assign pl_hb_usr_waddr = USR_BASE_ADDR;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr_xp10_decomp_lz77_pfx_ld.sv
`default_nettype none
// Directed, table-driven bench for the XP10 prefix loader.
`timescale 1ns/1ps
module tb_cr_xp10_decomp_lz77_pfx_ld;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pld_req = 1'b0;
    logic [1:0]   pld_sel = 2'd0;
    logic         pld_ack;
    logic         pld_valid = 1'b0;
    logic [127:0] pld_data = '0;
    logic         pld_ready;
    logic         pld_done;
    logic         frm_start = 1'b0;
    logic [1:0]   frm_pfx_sel = 2'd0;
    logic         ag_hb_eof = 1'b0;
    logic         wr0, wr1, wr2;
    logic [5:0]   wa0, wa1, wa2;
    logic [127:0] wd0, wd1, wd2;
    logic         iu0, iu1, iu2;
    logic         usr_valid = 1'b0;
    logic [127:0] usr_data = '0;
    logic         usr_ready;
    logic         usr_wr;
    logic [127:0] usr_wdata;
    logic [11:0]  usr_waddr;
    logic         conflict;

    int total = 0;
    int bad   = 0;

    bit mon_en = 1'b0;
    int n_wr0 = 0, n_wr1 = 0, n_wr2 = 0, n_done = 0, n_conf = 0;

    always #5 clk = ~clk;

    cr_xp10_decomp_lz77_pfx_ld #(.PFX_WORDS(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .pld_req(pld_req), .pld_sel(pld_sel), .pld_ack(pld_ack),
        .pld_valid(pld_valid), .pld_data(pld_data), .pld_ready(pld_ready),
        .pld_done(pld_done),
        .frm_start(frm_start), .frm_pfx_sel(frm_pfx_sel), .ag_hb_eof(ag_hb_eof),
        .pl_hb_pfx0_pld_wr(wr0), .pl_hb_pfx0_pld_waddr(wa0), .pl_hb_pfx0_pld_wdata(wd0),
        .pl_hb_pfx1_pld_wr(wr1), .pl_hb_pfx1_pld_waddr(wa1), .pl_hb_pfx1_pld_wdata(wd1),
        .pl_hb_pfx2_pld_wr(wr2), .pl_hb_pfx2_pld_waddr(wa2), .pl_hb_pfx2_pld_wdata(wd2),
        .pl_hb_pfx0_in_use(iu0), .pl_hb_pfx1_in_use(iu1), .pl_hb_pfx2_in_use(iu2),
        .usr_valid(usr_valid), .usr_data(usr_data), .usr_ready(usr_ready),
        .pl_hb_usr_wr(usr_wr), .pl_hb_usr_wdata(usr_wdata), .pl_hb_usr_waddr(usr_waddr),
        .pfx_conflict_err(conflict)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            n_wr0  += int'(wr0);
            n_wr1  += int'(wr1);
            n_wr2  += int'(wr2);
            n_done += int'(pld_done);
            n_conf += int'(conflict);
        end
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_wr0 = 0; n_wr1 = 0; n_wr2 = 0; n_done = 0; n_conf = 0;
    endtask

    function automatic logic [127:0] beat_data(input int sel, input int i);
        return {2'(sel), 120'h5A_0000_0000_0000_0000_0000_0000_0000, 6'(i)};
    endfunction

    // Full load into slot sel; optionally start a frame on that slot at beat conf_beat.
    task automatic do_load(input int sel, input int conf_beat);
        logic [2:0] exp_wr;
        logic [5:0] got_wa;
        logic [127:0] got_wd;
        pld_req = 1'b1;
        pld_sel = 2'(sel);
        #1;
        chk("ack_on_accept", {159'b0, pld_ack}, 160'd1);
        tick();
        pld_req = 1'b0;
        chk("ready_in_load", {159'b0, pld_ready}, 160'd1);
        exp_wr = 3'b001 << sel;
        for (int i = 0; i < 64; i++) begin
            pld_valid = 1'b1;
            pld_data  = beat_data(sel, i);
            if (i == conf_beat) begin
                frm_start   = 1'b1;
                frm_pfx_sel = 2'(sel);
            end
            tick();
            frm_start = 1'b0;
            got_wa = (sel == 0) ? wa0 : (sel == 1) ? wa1 : wa2;
            got_wd = (sel == 0) ? wd0 : (sel == 1) ? wd1 : wd2;
            chk("load_write", {25'b0, wr2, wr1, wr0, got_wa, got_wd},
                {25'b0, exp_wr, 6'(i), beat_data(sel, i)});
            if (i == conf_beat) chk("conflict_pulse", {159'b0, conflict}, 160'd1);
        end
        pld_valid = 1'b0;
        chk("done_pulse", {159'b0, pld_done}, 160'd1);
        tick();
        chk("done_clear", {158'b0, pld_done, pld_ready}, 160'd0);
    endtask

    typedef struct {
        logic       start;
        logic [1:0] fsel;
        logic       eof;
        logic       req;
        logic [1:0] rsel;
        logic [2:0] exp_iu;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b001};
        vecs[1] = '{1'b1, 2'd2, 1'b0, 1'b1, 2'd3, 3'b100};
        vecs[2] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 3'b100};
        vecs[3] = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 3'b000};
        vecs[4] = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 3'b010};
        vecs[5] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 3'b000};
        vecs[6] = '{1'b1, 2'd1, 1'b1, 1'b1, 2'd3, 3'b010};
        vecs[7] = '{1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 3'b000};
        vecs[8] = '{1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 3'b100};
        vecs[9] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 3'b000};

        // Reset values
        #3;
        chk("rst_ctrl", {150'b0, wr0, wr1, wr2, iu0, iu1, iu2, pld_ack, pld_done, pld_ready, conflict}, 160'd0);
        chk("rst_waddr", {142'b0, wa0, wa1, wa2}, 160'd0);
        chk("rst_wdata", {32'b0, wd0 | wd1 | wd2}, 160'd0);
        chk("rst_usr", {18'b0, usr_ready, usr_wr, usr_wdata, usr_waddr}, {148'b0, 12'd64});
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Frame in-use tracking table
        foreach (vecs[k]) begin
            frm_start   = vecs[k].start;
            frm_pfx_sel = vecs[k].fsel;
            ag_hb_eof   = vecs[k].eof;
            pld_req     = vecs[k].req;
            pld_sel     = vecs[k].rsel;
            #1;
            chk("tbl_ack", {159'b0, pld_ack}, 160'd0);
            tick();
            chk("tbl_in_use", {156'b0, conflict, iu2, iu1, iu0}, {156'b0, 1'b0, vecs[k].exp_iu});
        end
        frm_start = 1'b0; ag_hb_eof = 1'b0; pld_req = 1'b0;
        tick();

        // Basic slot-1 load
        clr_mon();
        mon_en = 1'b1;
        do_load(1, -1);
        tick();
        mon_en = 1'b0;
        chk("load1_counts", {32'(n_wr0), 32'(n_wr1), 32'(n_wr2), 32'(n_done), 32'(n_conf)},
            {32'd0, 32'd64, 32'd0, 32'd1, 32'd0});

        // Request to an in-use slot is held until end of frame
        frm_start = 1'b1; frm_pfx_sel = 2'd2;
        tick();
        frm_start = 1'b0;
        pld_req = 1'b1; pld_sel = 2'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("blocked_ack", {158'b0, iu2, pld_ack}, {158'b0, 2'b10});
            tick();
        end
        ag_hb_eof = 1'b1;
        #1;
        chk("blocked_ack_eof", {159'b0, pld_ack}, 160'd0);
        tick();
        ag_hb_eof = 1'b0;
        clr_mon();
        mon_en = 1'b1;
        do_load(2, -1);
        tick();
        mon_en = 1'b0;
        chk("load2_counts", {32'(n_wr0), 32'(n_wr1), 32'(n_wr2), 32'(n_done), 32'(n_conf)},
            {32'd0, 32'd0, 32'd64, 32'd1, 32'd0});

        // Frame start on the slot being loaded
        clr_mon();
        mon_en = 1'b1;
        do_load(0, 10);
        tick();
        mon_en = 1'b0;
        chk("conf_counts", {32'(n_wr0), 32'(n_wr1), 32'(n_wr2), 32'(n_done), 32'(n_conf)},
            {32'd64, 32'd0, 32'd0, 32'd1, 32'd1});
        chk("conf_in_use", {157'b0, iu2, iu1, iu0}, {157'b0, 3'b001});
        ag_hb_eof = 1'b1;
        tick();
        ag_hb_eof = 1'b0;

        // Reset in the middle of a load
        clr_mon();
        mon_en = 1'b1;
        pld_req = 1'b1; pld_sel = 2'd2;
        tick();
        pld_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            pld_valid = 1'b1;
            pld_data  = beat_data(2, i);
            tick();
        end
        pld_data = beat_data(2, 30);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {150'b0, wr0, wr1, wr2, iu0, iu1, iu2, pld_ack, pld_done, pld_ready, conflict}, 160'd0);
        chk("midrst_waddr", {142'b0, wa0, wa1, wa2}, 160'd0);
        chk("midrst_wdata", {32'b0, wd0 | wd1 | wd2}, 160'd0);
        tick();
        pld_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b0;
        chk("midrst_no_done", {128'b0, 32'(n_done)}, 160'd0);
        do_load(2, -1);
        tick();

`ifdef CR_XP10_DECOMP_PFX_LD_USR_EN
        // User data path: sequential addresses, eof reload, frame-start priority
        for (int i = 0; i < 3; i++) begin
            usr_valid = 1'b1;
            usr_data  = {32'hC0DE_0000 + 32'(i), 96'h0};
            tick();
            chk("usr_write", {19'b0, usr_wr, usr_wdata, usr_waddr},
                {19'b0, 1'b1, {32'hC0DE_0000 + 32'(i), 96'h0}, 12'd64 + 12'(i)});
        end
        usr_valid = 1'b0;
        ag_hb_eof = 1'b1;
        frm_start = 1'b1; frm_pfx_sel = 2'd1;
        #1;
        chk("usr_ready_eof", {159'b0, usr_ready}, 160'd0);
        tick();
        ag_hb_eof = 1'b0; frm_start = 1'b0;
        chk("eof_start_iu", {157'b0, iu2, iu1, iu0}, {157'b0, 3'b010});
        chk("usr_idle", {159'b0, usr_wr}, 160'd0);
        usr_valid = 1'b1;
        usr_data  = 128'hFEED;
        tick();
        usr_valid = 1'b0;
        chk("usr_after_eof", {19'b0, usr_wr, usr_wdata, usr_waddr}, {19'b0, 1'b1, 128'hFEED, 12'd64});
`else
        // User path absent: outputs remain tied off
        usr_valid = 1'b1;
        usr_data  = 128'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("usr_tied", {18'b0, usr_ready, usr_wr, usr_wdata, usr_waddr}, {148'b0, 12'd64});
        end
        usr_valid = 1'b0;
        ag_hb_eof = 1'b1;
        frm_start = 1'b1; frm_pfx_sel = 2'd1;
        tick();
        ag_hb_eof = 1'b0; frm_start = 1'b0;
        chk("eof_start_iu", {157'b0, iu2, iu1, iu0}, {157'b0, 3'b010});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cr_xp10_decomp_lz77_pfx_ld.md
CR_XP10_DECOMP_LZ77_PFX_LD -- requirements
Module: cr_xp10_decomp_lz77_pfx_ld

Interface
REQ-001 SHALL have parameter PFX_WORDS, default 64, meaning the number of 128-bit words per prefix RAM.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 SHALL have port pld_req, input, 1, requesting a prefix load; pld_sel, input, 2, the target slot 0..2.
REQ-005 SHALL have port pld_ack, output, 1, a one-cycle pulse when the request is accepted.
REQ-006 SHALL have port pld_valid, input, 1; pld_data, input, 128; pld_ready, output, 1; together these form the load data stream.
REQ-007 SHALL have port pld_done, output, 1, a one-cycle pulse after the last word is written.
REQ-008 SHALL have port frm_start, input, 1; frm_pfx_sel, input, 2 (3 = no prefix); ag_hb_eof, input, 1, marking frame end.
REQ-009 SHALL have ports pl_hb_pfxN_pld_wr, output, 1; pl_hb_pfxN_pld_waddr, output, 6; pl_hb_pfxN_pld_wdata, output, 128, for N = 0, 1, 2.
REQ-010 SHALL have ports pl_hb_pfxN_in_use, output, 1, for N = 0, 1, 2.
REQ-011 SHALL have ports usr_valid, input, 1; usr_data, input, 128; usr_ready, output, 1.
REQ-012 SHALL have ports pl_hb_usr_wr, output, 1; pl_hb_usr_wdata, output, 128; pl_hb_usr_waddr, output, 12.
REQ-013 SHALL have port pfx_conflict_err, output, 1, a one-cycle error pulse.

Function
REQ-014 SHALL implement the FSM IDLE -> LOAD -> DONE -> IDLE.
- IDLE -> LOAD when pld_req is high and slot pld_sel is not in_use and pld_sel != 3; pld_ack pulses that cycle.
- A request to an in_use slot SHALL be held unacknowledged until that slot clears.
REQ-015 In LOAD, pld_ready SHALL be 1, and the 6-bit word counter SHALL increment on each pld_valid&&pld_ready beat.
REQ-016 Each beat SHALL produce, exactly 1 cycle later, registered pl_hb_pfx<sel>_pld_wr=1 with waddr = the counter value and wdata = pld_data; the wr outputs of the other slots SHALL stay 0.
REQ-017 On the beat where the counter = PFX_WORDS-1, the FSM SHALL go to DONE; DONE SHALL pulse pld_done for one cycle and return to IDLE; the counter SHALL wrap to 0.
REQ-018 frm_start SHALL register in_use one-hot next cycle: the selected slot goes to 1 and all others to 0; frm_pfx_sel=3 SHALL clear all three.
REQ-019 ag_hb_eof SHALL clear all in_use bits next cycle. When ag_hb_eof and frm_start occur in the same cycle, frm_start SHALL win.
REQ-020 frm_start selecting the slot currently in LOAD SHALL still set in_use and SHALL pulse pfx_conflict_err; the load SHALL continue.
REQ-021 On a usr_valid&&usr_ready beat, pl_hb_usr_wr=1 with the registered data and address SHALL follow 1 cycle later. usr_ready SHALL be 1 except in the cycle where ag_hb_eof is high.
REQ-022 pl_hb_usr_waddr SHALL start at 12'd64, increment after each usr write, saturate at 12'd4095 with no wrap, and reload 12'd64 on ag_hb_eof.

Reset
REQ-023 On reset the following SHALL apply:
- FSM = IDLE; counter = 0.
- All wr, in_use, pld_ack, pld_done, pld_ready, usr_ready and pfx_conflict_err outputs = 0.
- All waddr and wdata outputs = 0.
- usr address = 12'd64.
REQ-024 Reset asserted mid-LOAD SHALL abort the load with no pld_done; the partially written prefix contents SHALL be undefined.

Configuration
REQ-025 With macro CR_XP10_DECOMP_PFX_LD_USR_EN defined, the user-data path (REQ-021 and REQ-022) SHALL be present.
REQ-026 Without CR_XP10_DECOMP_PFX_LD_USR_EN:
- usr_ready and pl_hb_usr_wr SHALL be tied to 0.
- pl_hb_usr_wdata SHALL be tied to 0.
- pl_hb_usr_waddr SHALL be tied to 12'd64.

Structure
REQ-027 The state enum pfx_ld_state_e and the constants PFX_NUM_SLOTS=3 and USR_BASE_ADDR=12'd64 SHALL reside in cr_xp10_decompPKG.
REQ-028 SHALL be a single module with no sub-module; the per-slot outputs SHALL be generated from a slot-indexed array.

Verification
REQ-029 Load test: pld_req with sel=1 while idle, then 64 beats of data = index -> pld_ack at cycle 0; 64 pfx1 writes with waddr 0..63; pld_done once; pfx0 and pfx2 wr never asserted.
REQ-030 Blocked request: frm_start with sel=2, then pld_req with sel=2 -> no pld_ack until ag_hb_eof, then pld_ack on the next cycle.
REQ-031 Conflict: frm_start with sel=0 during a slot-0 load at beat 10 -> pfx_conflict_err pulses once; all 64 writes still complete; pfx0_in_use=1.
REQ-032 User path: 3 usr beats -> waddr 64, 65, 66; ag_hb_eof -> next write at 64; same-cycle ag_hb_eof and frm_start with sel=1 -> pfx1_in_use=1.
REQ-033 Reset during beat 30 of a load -> all outputs return to reset values; a new pld_req is acked and the next write starts at waddr 0.
REQ-034 Build without CR_XP10_DECOMP_PFX_LD_USR_EN with usr_valid held at 1 -> pl_hb_usr_wr stays 0 and pl_hb_usr_waddr stays 64.
